// File: rtl/simmem_pkg.sv
// Shared widths and field types for the simmem ID queue bank.
// Default configuration only; the top derives its own widths from its parameters.
package simmem_pkg;

    localparam int unsigned DefStructWidth = 64;
    localparam int unsigned DefIdWidth     = 4;
    localparam int unsigned DefCapacity    = 64;

    localparam int unsigned DefNumIds   = 2 ** DefIdWidth;
    localparam int unsigned DefPtrWidth = $clog2(DefCapacity);
    localparam int unsigned DefCntWidth = $clog2(DefCapacity + 1);

    typedef logic [DefIdWidth-1:0]  id_t;
    typedef logic [DefPtrWidth-1:0] ptr_t;
    typedef logic [DefCntWidth-1:0] cnt_t;

endpackage

// File: rtl/simmem_rr_arbiter.sv
// Grant selection over per-ID requests: round-robin when SIMMEM_RR_ARBITER_EN is
// defined (search starts after the last granted ID), otherwise fixed lowest-index.
module simmem_rr_arbiter #(
    parameter  int unsigned IdWidth = 4,
    localparam int unsigned NumReq  = 2 ** IdWidth
) (
`ifdef SIMMEM_RR_ARBITER_EN
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               advance_i,
`endif
    input  logic [NumReq-1:0]  req_i,
    output logic [NumReq-1:0]  gnt_oh_o,
    output logic [IdWidth-1:0] gnt_idx_o
);

`ifdef SIMMEM_RR_ARBITER_EN
    // start_reg holds the first ID to examine, i.e. last granted ID + 1.
    logic [IdWidth-1:0] start_reg;
    logic [IdWidth-1:0] search_idx;
    logic               found;

    always_comb begin
        gnt_idx_o  = start_reg;
        search_idx = start_reg;
        found      = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            search_idx = start_reg + IdWidth'(k);
            if (!found && req_i[search_idx]) begin
                gnt_idx_o = search_idx;
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_reg <= '0;
        end else if (advance_i) begin
            start_reg <= gnt_idx_o + IdWidth'(1);
        end
    end
`else
    always_comb begin
        gnt_idx_o = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                gnt_idx_o = IdWidth'(k);
            end
        end
    end
`endif

    assign gnt_oh_o = (|req_i) ? (NumReq'(1) << gnt_idx_o) : '0;

endmodule

// File: rtl/simmem_id_queue_bank.sv
// Per-ID FIFO linked lists sharing one entry pool; released messages chosen by
// simmem_rr_arbiter. Define SIMMEM_RR_ARBITER_EN for round-robin release order.
module simmem_id_queue_bank
    import simmem_pkg::*;
#(
    parameter  int unsigned StructWidth = DefStructWidth,
    parameter  int unsigned IdWidth     = DefIdWidth,
    parameter  int unsigned Capacity    = DefCapacity,
    localparam int unsigned NumIds      = 2 ** IdWidth,
    localparam int unsigned PtrWidth    = $clog2(Capacity),
    localparam int unsigned CntWidth    = $clog2(Capacity + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumIds-1:0]      release_en_i,
    input  logic [StructWidth-1:0] data_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [StructWidth-1:0] data_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [CntWidth-1:0]    free_cnt_o
);

    localparam int unsigned PayloadWidth = StructWidth - IdWidth;

    logic [PayloadWidth-1:0] payload_mem [Capacity];
    logic [PtrWidth-1:0]     next_mem    [Capacity];

    logic [Capacity-1:0]               occupied_reg;
    logic [CntWidth-1:0]               free_cnt_reg;
    logic [NumIds-1:0][PtrWidth-1:0]   head_reg, head_next;
    logic [NumIds-1:0][PtrWidth-1:0]   tail_reg, tail_next;
    logic [NumIds-1:0][CntWidth-1:0]   len_reg, len_next;

    logic [PtrWidth-1:0] free_slot;
    logic [IdWidth-1:0]  push_id;
    logic [IdWidth-1:0]  gnt_id;
    logic [NumIds-1:0]   eligible;
    logic [NumIds-1:0]   gnt_oh;
    logic                push;
    logic                pop;

    assign push_id     = data_i[IdWidth-1:0];
    assign in_ready_o  = (free_cnt_reg != '0);
    assign free_cnt_o  = free_cnt_reg;
    assign out_valid_o = |eligible;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign data_o      = {payload_mem[head_reg[gnt_id]], gnt_id};

    // Lowest-index free entry of the registered bitmap; a slot freed this cycle
    // only becomes visible here on the next cycle.
    always_comb begin
        free_slot = '0;
        for (int i = Capacity - 1; i >= 0; i--) begin
            if (!occupied_reg[i]) begin
                free_slot = PtrWidth'(i);
            end
        end
    end

    for (genvar gi = 0; gi < NumIds; gi++) begin : g_id
        logic push_hit;
        logic pop_hit;

        assign eligible[gi] = release_en_i[gi] && (len_reg[gi] != '0);
        assign push_hit     = push && (push_id == IdWidth'(gi));
        assign pop_hit      = pop && gnt_oh[gi];

        // Popping the last entry while appending leaves the new slot as sole entry.
        assign head_next[gi] = pop_hit
            ? ((push_hit && len_reg[gi] == CntWidth'(1)) ? free_slot : next_mem[head_reg[gi]])
            : ((push_hit && len_reg[gi] == '0) ? free_slot : head_reg[gi]);
        assign tail_next[gi] = push_hit ? free_slot : tail_reg[gi];
        assign len_next[gi]  = len_reg[gi] + CntWidth'(push_hit) - CntWidth'(pop_hit);
    end

    simmem_rr_arbiter #(
        .IdWidth (IdWidth)
    ) u_arbiter (
`ifdef SIMMEM_RR_ARBITER_EN
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .advance_i (pop),
`endif
        .req_i     (eligible),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_id)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occupied_reg <= '0;
            free_cnt_reg <= CntWidth'(Capacity);
            head_reg     <= '0;
            tail_reg     <= '0;
            len_reg      <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            len_reg  <= len_next;
            if (push) begin
                occupied_reg[free_slot] <= 1'b1;
            end
            if (pop) begin
                occupied_reg[head_reg[gnt_id]] <= 1'b0;
            end
            if (push && !pop) begin
                free_cnt_reg <= free_cnt_reg - CntWidth'(1);
            end else if (pop && !push) begin
                free_cnt_reg <= free_cnt_reg + CntWidth'(1);
            end
        end
    end

    // Storage arrays carry no reset; occupancy and list state define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            payload_mem[free_slot] <= data_i[StructWidth-1:IdWidth];
            if (len_reg[push_id] != '0) begin
                next_mem[tail_reg[push_id]] <= free_slot;
            end
        end
    end

endmodule

// File: tb/tb_simmem_id_queue_bank.sv
// Randomized and directed bench for simmem_id_queue_bank against a queue-based model.
module tb_simmem_id_queue_bank;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] release_en_i;
    logic [63:0] data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [6:0]  free_cnt_o;

    simmem_id_queue_bank dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .release_en_i (release_en_i),
        .data_i       (data_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .data_o       (data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .free_cnt_o   (free_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: one FIFO of payloads per ID plus round-robin start ID.
    bit [59:0] mq [16][$];
    int        rr_next = 0;
    int        check_cnt = 0;
    int        pass_cnt = 0;
    int        last_gnt = -1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic int model_total();
        int t = 0;
        for (int i = 0; i < 16; i++) t += mq[i].size();
        return t;
    endfunction

    function automatic int model_grant(input logic [15:0] en);
        int start;
`ifdef SIMMEM_RR_ARBITER_EN
        start = rr_next;
`else
        start = 0;
`endif
        for (int k = 0; k < 16; k++) begin
            int id = (start + k) % 16;
            if (en[id] && mq[id].size() != 0) return id;
        end
        return -1;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) mq[i].delete();
        rr_next = 0;
    endfunction

    // One clock cycle: drive at negedge, check outputs, update model at posedge.
    task automatic step(input logic iv, input logic [63:0] d, input logic [15:0] en, input logic ordy);
        int          g;
        int          exp_free;
        logic        do_push;
        logic        do_pop;
        logic [63:0] exp_d;
        in_valid_i   = iv;
        data_i       = d;
        release_en_i = en;
        out_ready_i  = ordy;
        #1;
        exp_free = 64 - model_total();
        g        = model_grant(en);
        check_eq("in_ready", 64'(in_ready_o), 64'(exp_free != 0));
        check_eq("free_cnt", 64'(free_cnt_o), 64'(exp_free));
        check_eq("out_valid", 64'(out_valid_o), 64'(g >= 0));
        last_gnt = -1;
        if (g >= 0) begin
            exp_d = {mq[g][0], 4'(g)};
            check_eq("data_o", data_o, exp_d);
            last_gnt = int'(data_o[3:0]);
        end
        do_push = iv && (exp_free != 0);
        do_pop  = (g >= 0) && ordy;
        @(posedge clk_i);
        if (do_pop) begin
            void'(mq[g].pop_front());
            rr_next = (g + 1) % 16;
        end
        if (do_push) mq[d[3:0]].push_back(d[63:4]);
        if (do_push || do_pop)
            $display("xact t=%0t push=%0b id=%0d pop=%0b gnt=%0d stored=%0d",
                     $time, do_push, d[3:0], do_pop, g, model_total());
        @(negedge clk_i);
    endtask

    function automatic logic [63:0] msg(input int id);
        logic [63:0] m;
        m      = {$urandom, $urandom};
        m[3:0] = 4'(id);
        return m;
    endfunction

    task automatic drain();
        for (int n = 0; n < 200 && model_total() != 0; n++)
            step(1'b0, msg(0), 16'hFFFF, 1'b1);
        check_eq("drained", 64'(model_total()), 64'd0);
    endtask

    task automatic reset_pulse();
        rst_i        = 1'b1;
        in_valid_i   = 1'b0;
        release_en_i = 16'hFFFF;
        out_ready_i  = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid_o), 64'd0);
        check_eq("rst_free_cnt", 64'(free_cnt_o), 64'd64);
        check_eq("rst_in_ready", 64'(in_ready_o), 64'd1);
        model_clear();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] m;
        int          exp_order [6];
        rst_i        = 1'b1;
        in_valid_i   = 1'b0;
        data_i       = '0;
        release_en_i = 16'hFFFF;
        out_ready_i  = 1'b0;
        @(negedge clk_i);
        reset_pulse();

        // Push to ID 3 held back, then released.
        step(1'b1, msg(3), 16'h0000, 1'b0);
        step(1'b0, msg(0), 16'h0000, 1'b0);
        step(1'b0, msg(0), 16'h0008, 1'b0);
        step(1'b0, msg(0), 16'h0008, 1'b1);

        // In-order release of three messages on ID 5.
        for (int i = 0; i < 3; i++) step(1'b1, msg(5), 16'h0000, 1'b0);
        drain();
        check_eq("free_after_id5", 64'(free_cnt_o), 64'd64);

        // Fill completely, then pop with a concurrent push attempt.
        for (int i = 0; i < 64; i++) step(1'b1, msg(int'($urandom_range(0, 15))), 16'h0000, 1'b0);
        step(1'b1, msg(7), 16'hFFFF, 1'b1);
        step(1'b1, msg(7), 16'h0000, 1'b0);
        step(1'b0, msg(0), 16'h0000, 1'b0);
        drain();

        // Same-ID push and pop with a single stored entry.
        step(1'b1, msg(2), 16'h0000, 1'b0);
        step(1'b1, msg(2), 16'h0004, 1'b1);
        step(1'b0, msg(0), 16'h0004, 1'b0);
        check_eq("id2_len", 64'(mq[2].size()), 64'd1);
        drain();

        // Grant order with two entries on each of IDs 0..2.
        reset_pulse();
        for (int r = 0; r < 2; r++)
            for (int id = 0; id < 3; id++) step(1'b1, msg(id), 16'h0000, 1'b0);
`ifdef SIMMEM_RR_ARBITER_EN
        exp_order = '{0, 1, 2, 0, 1, 2};
`else
        exp_order = '{0, 0, 1, 1, 2, 2};
`endif
        for (int i = 0; i < 6; i++) begin
            step(1'b0, msg(0), 16'hFFFF, 1'b1);
            check_eq("grant_order", 64'(last_gnt), 64'(exp_order[i]));
        end

        // Randomized traffic with contention across a few hot IDs.
        for (int n = 0; n < 800; n++) begin
            int id;
            id = ($urandom_range(0, 9) < 6) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
            m  = msg(id);
            step(1'($urandom_range(0, 9) < 6), m, 16'($urandom), 1'($urandom_range(0, 1)));
        end

        // Mid-operation reset with stored entries, then normal use of ID 0.
        for (int i = 0; i < 10; i++) step(1'b1, msg(int'($urandom_range(0, 15))), 16'h0000, 1'b0);
        reset_pulse();
        step(1'b1, msg(0), 16'h0000, 1'b0);
        step(1'b0, msg(0), 16'h0001, 1'b1);
        step(1'b0, msg(0), 16'h0001, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
